// File: rtl/data_mem_pkg.sv
// Shared types and constants for the MEM-stage data memory responder.
package data_mem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } resp_state_t;

endpackage

// File: rtl/data_mem_responder_sp_ram.sv
// Single-port synchronous RAM: write-enable, registered read, no reset.
module sp_ram #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rdata;

    // Enabled access: write stores, read captures old contents into r_rdata.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: one access at a time, programmable wait
// states, valid/ready response channel and a combinational pipeline stall.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              stall
);

    localparam logic [CNT_W-1:0] LAT_C   = CNT_W'(LATENCY);
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W + 1)'(DEPTH);

    resp_state_t       r_state;
    resp_state_t       w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic              r_resp_rd;
    logic              r_resp_err;
    logic              w_in_range;
    logic              w_perform;
    logic [WORD_W-1:0] w_ram_rdata;

    assign w_in_range = ({1'b0, r_addr} < DEPTH_C);
    assign w_perform  = (r_state == WAIT) && (r_cnt == '0);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs; illegal encodings fall back to IDLE.
    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Request latch on acceptance and wait-state countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if ((r_state == IDLE) && req_valid) begin
            r_cnt   <= LAT_C;
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end else if ((r_state == WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Response status captured when the access is performed, held afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_rd  <= 1'b0;
            r_resp_err <= 1'b0;
        end else if (w_perform) begin
            r_resp_rd  <= ~r_write & w_in_range;
            r_resp_err <= ~w_in_range;
        end
    end

    // RAM read register only moves on a performed in-range read, so gating
    // it with r_resp_rd gives zero for writes, errors and after reset.
    sp_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_perform & w_in_range),
        .i_we    (r_write),
        .i_addr  (r_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign resp_rdata = r_resp_rd ? w_ram_rdata : '0;
    assign resp_err   = r_resp_err;
    assign stall      = req_valid & ~req_ready;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two builds (LATENCY=2/DEPTH=1000 and
// LATENCY=0/DEPTH=1024) against a transaction-level memory model.
module tb_data_mem_responder;

    localparam int LAT_A = 2;
    localparam int DEP_A = 1000;
    localparam int LAT_B = 0;
    localparam int DEP_B = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [9:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_ready = 1'b0;

    logic        a_req_ready, a_resp_valid, a_resp_err, a_stall;
    logic [31:0] a_resp_rdata;
    logic        b_req_ready, b_resp_valid, b_resp_err, b_stall;
    logic [31:0] b_resp_rdata;

    logic        m_req_ready, m_resp_valid, m_err, m_stall;
    logic [31:0] m_rdata;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] mem [2][1024];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.ADDR_W(10), .DEPTH(DEP_A), .LATENCY(LAT_A)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid & ~sel),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (a_req_ready),
        .resp_valid (a_resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (a_resp_rdata),
        .resp_err   (a_resp_err),
        .stall      (a_stall)
    );

    data_mem_responder #(.ADDR_W(10), .DEPTH(DEP_B), .LATENCY(LAT_B)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid & sel),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (b_req_ready),
        .resp_valid (b_resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (b_resp_rdata),
        .resp_err   (b_resp_err),
        .stall      (b_stall)
    );

    assign m_req_ready  = sel ? b_req_ready  : a_req_ready;
    assign m_resp_valid = sel ? b_resp_valid : a_resp_valid;
    assign m_err        = sel ? b_resp_err   : a_resp_err;
    assign m_stall      = sel ? b_stall      : a_stall;
    assign m_rdata      = sel ? b_resp_rdata : a_resp_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction starting and ending at a negedge.
    task automatic txn(input logic s, input logic we, input logic [9:0] addr,
                       input logic [31:0] wd, input int bp,
                       output logic [31:0] rd, output int acc);
        int          n;
        int          lat;
        logic        exp_err;
        logic [31:0] exp_rd;
        lat     = s ? LAT_B : LAT_A;
        exp_err = (int'(addr) >= (s ? DEP_B : DEP_A));
        exp_rd  = (we || exp_err) ? 32'h0 : mem[s][addr];
        sel = s; req_write = we; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        #1;
        chk("idle_ready", m_req_ready, 1);
        chk("idle_stall", m_stall, 0);
        @(posedge clk);
        #1;
        acc = cyc;
        req_valid = 1'b0;
        if (we && !exp_err) mem[s][addr] = wd;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (m_resp_valid) break;
            n++;
        end
        chk("latency", n, lat + 1);
        chk("rdata", m_rdata, exp_rd);
        chk("err", m_err, exp_err);
        rd = m_rdata;
        for (int i = 0; i < bp; i++) begin
            req_valid = 1'b1;
            #1;
            chk("bp_stall", m_stall, 1);
            req_valid = 1'b0;
            @(negedge clk);
            chk("bp_valid", m_resp_valid, 1);
            chk("bp_rdata", m_rdata, exp_rd);
            chk("bp_err", m_err, exp_err);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk("done_valid", m_resp_valid, 0);
        chk("done_ready", m_req_ready, 1);
        chk("hold_rdata", m_rdata, exp_rd);
        chk("hold_err", m_err, exp_err);
    endtask

    initial begin
        logic [31:0] rd;
        int          acc0, acc1, n, cnt;
        logic [9:0]  pool [8];
        pool = '{10'd0, 10'd3, 10'd5, 10'd7, 10'd998, 10'd999, 10'd1000, 10'd1023};

        // Reset state of both builds.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready_a", a_req_ready, 1);
        chk("rst_valid_a", a_resp_valid, 0);
        chk("rst_rdata_a", a_resp_rdata, 0);
        chk("rst_err_a", a_resp_err, 0);
        chk("rst_ready_b", b_req_ready, 1);
        chk("rst_valid_b", b_resp_valid, 0);
        chk("rst_rdata_b", b_resp_rdata, 0);

        // Give every pool address a known value in both builds.
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 8; i++)
                txn(s[0], 1'b1, pool[i], 32'h1000_0000 * (s + 1) + 32'(pool[i]), 0, rd, acc0);

        // Reset mid-WAIT drops the pending write.
        sel = 1'b0; req_write = 1'b1; req_addr = 10'd5; req_wdata = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_ready", a_req_ready, 1);
        chk("rst2_valid", a_resp_valid, 0);
        chk("rst2_rdata", a_resp_rdata, 0);
        chk("rst2_stall", a_stall, 0);
        txn(1'b0, 1'b0, 10'd5, 32'h0, 0, rd, acc0);
        chk("rst2_not_written", 32'(rd == 32'hDEAD_BEEF), 0);

        // Write then read, LATENCY=2; then back-pressure for 5 cycles.
        txn(1'b0, 1'b1, 10'd3, 32'h1234_5678, 0, rd, acc0);
        txn(1'b0, 1'b0, 10'd3, 32'h0, 0, rd, acc0);
        chk("wr_rd_3", rd, 32'h1234_5678);
        txn(1'b0, 1'b0, 10'd3, 32'h0, 5, rd, acc0);

        // LATENCY=0 build: back-to-back transactions every 3 cycles.
        txn(1'b1, 1'b1, 10'd0, 32'hA5A5_A5A5, 0, rd, acc0);
        txn(1'b1, 1'b0, 10'd0, 32'h0, 0, rd, acc1);
        chk("lat0_rdata", rd, 32'hA5A5_A5A5);
        chk("lat0_period", acc1 - acc0, LAT_B + 3);
        txn(1'b0, 1'b0, 10'd0, 32'h0, 0, rd, acc0);
        txn(1'b0, 1'b0, 10'd5, 32'h0, 0, rd, acc1);
        chk("lat2_period", acc1 - acc0, LAT_A + 3);

        // Out of range on the DEPTH=1000 build.
        txn(1'b0, 1'b1, 10'd1000, 32'hFFFF_FFFF, 0, rd, acc0);
        txn(1'b0, 1'b0, 10'd1000, 32'h0, 0, rd, acc0);
        txn(1'b0, 1'b0, 10'd999, 32'h0, 0, rd, acc0);
        chk("oor_999_kept", rd, 32'h1000_0000 + 32'd999);

        // Request held during WAIT/RESP is ignored, then accepted once.
        sel = 1'b0; req_write = 1'b0; req_addr = 10'd3; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_addr = 10'd7;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (m_resp_valid) break;
            chk("ign_stall_wait", m_stall, 1);
            n++;
        end
        chk("ign_first_lat", n, LAT_A + 1);
        chk("ign_first_rdata", m_rdata, mem[0][3]);
        chk("ign_stall_resp", m_stall, 1);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk("ign_idle_ready", m_req_ready, 1);
        chk("ign_idle_stall", m_stall, 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        resp_ready = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (m_resp_valid) begin
                cnt++;
                chk("ign_second_rdata", m_rdata, mem[0][7]);
            end
        end
        chk("ign_once", cnt, 1);
        resp_ready = 1'b0;

        // Randomized traffic on both builds.
        for (int k = 0; k < 40; k++) begin
            txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                pool[$urandom_range(0, 7)], $urandom, $urandom_range(0, 2), rd, acc0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
